// File: rtl/uart_port_arbiter.sv
// uart_port_arbiter: shares one simpleuart reg_dat port between NREQ
// round-robin transmit requesters and a single receive consumer.
// TX: IDLE grants one requester (tx_ready pulse) and latches its byte, WRITE
// holds reg_dat_we until the UART stops asserting reg_dat_wait.
// RX: polls reg_dat_do, captures a byte into a 1-deep holding register and
// pops it from the UART with a single-cycle reg_dat_re pulse.
// Optional build macro UART_PORT_ARBITER_ECHO_EN: every captured RX byte is
// also queued for retransmission, ahead of all requesters.

module uart_port_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic                hw_clk,
    input  logic                resetn,
    input  logic [NREQ-1:0]     tx_valid,
    input  logic [8*NREQ-1:0]   tx_data,
    output logic [NREQ-1:0]     tx_ready,
    output logic                rx_valid,
    output logic [7:0]          rx_data,
    input  logic                rx_ready,
    output logic                busy,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                reg_dat_we,
    output logic                reg_dat_re,
    output logic [31:0]         reg_dat_di,
    input  logic [31:0]         reg_dat_do,
    input  logic                reg_dat_wait
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } tx_state_t;

    tx_state_t          r_state;
    tx_state_t          w_state_nxt;
    logic [IDX_W-1:0]   r_rr;
    logic [IDX_W-1:0]   r_grant;
    logic [7:0]         r_di;
    logic [IDX_W-1:0]   w_sel;
    logic [NREQ-1:0]    w_ready;
    logic               w_start;
    logic               w_accept;
    logic [7:0]         w_bytes [NREQ];

    logic               r_rx_valid;
    logic [7:0]         r_rx_data;
    logic               r_re;
    logic               r_re_d;
    logic               w_capture;

    logic               w_echo_pend;
    logic [7:0]         w_echo_byte;
    logic               w_echo_wr;
    logic               w_unused_do;

    // Only bit 31 (empty flag) and the low byte of reg_dat_do carry meaning.
    assign w_unused_do = ^reg_dat_do[30:8];

    for (genvar g = 0; g < NREQ; g++) begin : g_bytes
        assign w_bytes[g] = tx_data[8*g +: 8];
    end

    // Round-robin pick: first valid requester at or above r_rr, wrapping.
    always_comb begin : p_arb
        int                 k;
        logic [IDX_W-1:0]   kk;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_sel = '0;
        k     = 0;
        kk    = '0;
        // Scan downward so the lowest rotated position wins the last write.
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = i + int'(r_rr);
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            kk = IDX_W'(k);
            if (tx_valid[kk]) begin
                w_sel = kk;
            end
        end
    end

    // TX state register.
    always_ff @(posedge hw_clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // TX next-state and grant strobes; a pending echo outranks all requesters.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_echo_pend) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_WRITE;
                end else if (|tx_valid) begin
                    w_start        = 1'b1;
                    w_ready[w_sel] = 1'b1;
                    w_state_nxt    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!reg_dat_wait) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // TX datapath: byte latch, grant index and round-robin pointer.
    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            r_di    <= 8'h00;
            r_grant <= '0;
            r_rr    <= '0;
        end else begin
            if (w_start) begin
                if (w_echo_pend) begin
                    r_di <= w_echo_byte;
                end else begin
                    r_di    <= w_bytes[w_sel];
                    r_grant <= w_sel;
                end
            end
            // Echo writes leave the fairness pointer alone.
            if (w_accept && !w_echo_wr) begin
                r_rr <= (r_grant == IDX_W'(NREQ - 1)) ? '0 : r_grant + 1'b1;
            end
        end
    end

    // Capture only when empty, UART non-empty, past the stale-read cycle, and echo slot free.
    assign w_capture = !r_rx_valid && !reg_dat_do[31] && !r_re_d && !w_echo_pend;

    // RX holding register and single-cycle pop strobe.
    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
            r_re       <= 1'b0;
            r_re_d     <= 1'b0;
        end else begin
            if (w_capture) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= reg_dat_do[7:0];
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            r_re   <= w_capture;
            r_re_d <= r_re;
        end
    end

`ifdef UART_PORT_ARBITER_ECHO_EN
    logic       r_echo_pend;
    logic [7:0] r_echo_byte;
    logic       r_echo_wr;

    // One-entry echo slot: filled on capture, freed when its write is accepted.
    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            r_echo_pend <= 1'b0;
            r_echo_byte <= 8'h00;
            r_echo_wr   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_echo_pend <= 1'b1;
                r_echo_byte <= reg_dat_do[7:0];
            end else if (w_accept && r_echo_wr) begin
                r_echo_pend <= 1'b0;
            end
            if (w_start) begin
                r_echo_wr <= r_echo_pend;
            end
        end
    end

    assign w_echo_pend = r_echo_pend;
    assign w_echo_byte = r_echo_byte;
    assign w_echo_wr   = r_echo_wr;
`else
    assign w_echo_pend = 1'b0;
    assign w_echo_byte = 8'h00;
    assign w_echo_wr   = 1'b0;
`endif

    // Grant strobe is masked during reset so a requester never sees a lost handshake.
    assign tx_ready   = w_ready & {NREQ{resetn}};
    assign reg_dat_we = (r_state == ST_WRITE);
    assign busy       = (r_state == ST_WRITE);
    assign reg_dat_di = {24'h000000, r_di};
    assign grant_idx  = r_grant;
    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;
    assign reg_dat_re = r_re;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed bench for uart_port_arbiter (NREQ=4): per-cycle vector table
// for grant/round-robin/RX drain, plus hand sequences for a long write stall
// with concurrent RX, mid-transfer reset, and the echo build.

module tb_uart_port_arbiter;

    logic        hw_clk = 1'b0;
    logic        resetn;
    logic [3:0]  tx_valid;
    logic [31:0] tx_data;
    logic [3:0]  tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        busy;
    logic [1:0]  grant_idx;
    logic        reg_dat_we;
    logic        reg_dat_re;
    logic [31:0] reg_dat_di;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] FF  = 32'hFFFF_FFFF;
    localparam logic [31:0] DRR = 32'hD3D2_D1D0;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        wt;
        logic [31:0] dout;
        logic        rdy;
        logic [3:0]  e_ready;
        logic        e_we;
        logic [7:0]  e_di;
        logic [1:0]  e_grant;
        logic        e_re;
        logic        e_rxv;
        logic [7:0]  e_rxd;
    } vec_t;

    vec_t tbl[$];

    uart_port_arbiter #(.NREQ(4), .IDX_W(2)) dut (
        .hw_clk       (hw_clk),
        .resetn       (resetn),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .busy         (busy),
        .grant_idx    (grant_idx),
        .reg_dat_we   (reg_dat_we),
        .reg_dat_re   (reg_dat_re),
        .reg_dat_di   (reg_dat_di),
        .reg_dat_do   (reg_dat_do),
        .reg_dat_wait (reg_dat_wait)
    );

    always #5 hw_clk = ~hw_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] valid, input logic [31:0] data, input logic wt,
                                input logic [31:0] dout, input logic rdy, input logic [3:0] e_ready,
                                input logic e_we, input logic [7:0] e_di, input logic [1:0] e_grant,
                                input logic e_re, input logic e_rxv, input logic [7:0] e_rxd);
        vec_t v;
        v.valid = valid; v.data = data; v.wt = wt; v.dout = dout; v.rdy = rdy;
        v.e_ready = e_ready; v.e_we = e_we; v.e_di = e_di; v.e_grant = e_grant;
        v.e_re = e_re; v.e_rxv = e_rxv; v.e_rxd = e_rxd;
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge, then compare all outputs.
    task automatic apply(input vec_t v, input string tag);
        @(negedge hw_clk);
        tx_valid     = v.valid;
        tx_data      = v.data;
        reg_dat_wait = v.wt;
        reg_dat_do   = v.dout;
        rx_ready     = v.rdy;
        #1;
        check({tag, ".tx_ready"},   32'(tx_ready),   32'(v.e_ready));
        check({tag, ".we"},         32'(reg_dat_we), 32'(v.e_we));
        check({tag, ".busy"},       32'(busy),       32'(v.e_we));
        check({tag, ".di"},         reg_dat_di,      {24'h0, v.e_di});
        check({tag, ".grant_idx"},  32'(grant_idx),  32'(v.e_grant));
        check({tag, ".re"},         32'(reg_dat_re), 32'(v.e_re));
        check({tag, ".rx_valid"},   32'(rx_valid),   32'(v.e_rxv));
        check({tag, ".rx_data"},    32'(rx_data),    32'(v.e_rxd));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".tx_ready"},  32'(tx_ready),   32'h0);
        check({tag, ".we"},        32'(reg_dat_we), 32'h0);
        check({tag, ".re"},        32'(reg_dat_re), 32'h0);
        check({tag, ".busy"},      32'(busy),       32'h0);
        check({tag, ".di"},        reg_dat_di,      32'h0);
        check({tag, ".grant_idx"}, 32'(grant_idx),  32'h0);
        check({tag, ".rx_valid"},  32'(rx_valid),   32'h0);
        check({tag, ".rx_data"},   32'(rx_data),    32'h0);
    endtask

    initial begin
        resetn       = 1'b0;
        tx_valid     = 4'h0;
        tx_data      = 32'h0;
        rx_ready     = 1'b0;
        reg_dat_do   = FF;
        reg_dat_wait = 1'b0;
        repeat (2) @(negedge hw_clk);
        #1;
        check_reset_values("reset");
        @(negedge hw_clk);
        resetn = 1'b1;

`ifndef UART_PORT_ARBITER_ECHO_EN
        // Single request, then round-robin from rr=1, then wrap-around skip.
        tbl.push_back(mk(4'b0001, 32'h50, 0, FF, 0, 4'b0001, 0, 8'h00, 0, 0, 0, 8'h00));
        tbl.push_back(mk(4'b0000, 32'h50, 0, FF, 0, 4'b0000, 1, 8'h50, 0, 0, 0, 8'h00));
        tbl.push_back(mk(4'b0000, DRR,    0, FF, 0, 4'b0000, 0, 8'h50, 0, 0, 0, 8'h00));
        tbl.push_back(mk(4'b1111, DRR,    0, FF, 0, 4'b0010, 0, 8'h50, 0, 0, 0, 8'h00));
        tbl.push_back(mk(4'b1111, DRR,    0, FF, 0, 4'b0000, 1, 8'hD1, 1, 0, 0, 8'h00));
        tbl.push_back(mk(4'b1111, DRR,    0, FF, 0, 4'b0100, 0, 8'hD1, 1, 0, 0, 8'h00));
        tbl.push_back(mk(4'b1111, DRR,    0, FF, 0, 4'b0000, 1, 8'hD2, 2, 0, 0, 8'h00));
        tbl.push_back(mk(4'b1111, DRR,    0, FF, 0, 4'b1000, 0, 8'hD2, 2, 0, 0, 8'h00));
        tbl.push_back(mk(4'b1111, DRR,    0, FF, 0, 4'b0000, 1, 8'hD3, 3, 0, 0, 8'h00));
        tbl.push_back(mk(4'b1111, DRR,    0, FF, 0, 4'b0001, 0, 8'hD3, 3, 0, 0, 8'h00));
        tbl.push_back(mk(4'b1001, DRR,    0, FF, 0, 4'b0000, 1, 8'hD0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(4'b1001, DRR,    0, FF, 0, 4'b1000, 0, 8'hD0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(4'b0000, DRR,    0, FF, 0, 4'b0000, 1, 8'hD3, 3, 0, 0, 8'h00));
        tbl.push_back(mk(4'b0000, DRR,    0, FF, 0, 4'b0000, 0, 8'hD3, 3, 0, 0, 8'h00));
        // RX drain, hold-while-full, clear then second capture.
        tbl.push_back(mk(4'b0000, DRR, 0, 32'h35, 0, 4'b0, 0, 8'hD3, 3, 0, 0, 8'h00));
        tbl.push_back(mk(4'b0000, DRR, 0, 32'h35, 0, 4'b0, 0, 8'hD3, 3, 1, 1, 8'h35));
        tbl.push_back(mk(4'b0000, DRR, 0, FF,     0, 4'b0, 0, 8'hD3, 3, 0, 1, 8'h35));
        tbl.push_back(mk(4'b0000, DRR, 0, 32'h36, 0, 4'b0, 0, 8'hD3, 3, 0, 1, 8'h35));
        tbl.push_back(mk(4'b0000, DRR, 0, 32'h36, 0, 4'b0, 0, 8'hD3, 3, 0, 1, 8'h35));
        tbl.push_back(mk(4'b0000, DRR, 0, 32'h36, 1, 4'b0, 0, 8'hD3, 3, 0, 1, 8'h35));
        tbl.push_back(mk(4'b0000, DRR, 0, 32'h36, 0, 4'b0, 0, 8'hD3, 3, 0, 0, 8'h35));
        tbl.push_back(mk(4'b0000, DRR, 0, 32'h36, 0, 4'b0, 0, 8'hD3, 3, 1, 1, 8'h36));
        tbl.push_back(mk(4'b0000, DRR, 0, FF,     1, 4'b0, 0, 8'hD3, 3, 0, 1, 8'h36));
        tbl.push_back(mk(4'b0000, DRR, 0, FF,     0, 4'b0, 0, 8'hD3, 3, 0, 0, 8'h36));
        // Stale reg_dat_do with an always-ready consumer: capture every 3rd cycle.
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(4'b0000, DRR, 0, 32'h77, 1, 4'b0, 0, 8'hD3, 3,
                             (i % 3 == 1), (i % 3 == 1), (i == 0) ? 8'h36 : 8'h77));
        end
        tbl.push_back(mk(4'b0000, DRR, 0, FF, 0, 4'b0, 0, 8'hD3, 3, 0, 0, 8'h77));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Stall: requester 2 sends 0x31 with wait high 20 cycles; RX byte arrives mid-stall.
        apply(mk(4'b0100, 32'hD331_D1D0, 0, FF, 0, 4'b0100, 0, 8'hD3, 3, 0, 0, 8'h77), "stall0");
        for (int k = 1; k <= 21; k++) begin
            apply(mk(4'b1111, 32'hD331_D1D0, (k <= 20), (k == 5 || k == 6) ? 32'h5A : FF, 0,
                     4'b0000, 1, 8'h31, 2, (k == 6), (k >= 6), (k >= 6) ? 8'h5A : 8'h77),
                  $sformatf("stall%0d", k));
        end
        apply(mk(4'b1111, 32'hD331_D1D0, 0, FF, 0, 4'b1000, 0, 8'h31, 2, 0, 1, 8'h5A), "stall22");
        apply(mk(4'b0000, 32'hD331_D1D0, 0, FF, 0, 4'b0000, 1, 8'hD3, 3, 0, 1, 8'h5A), "stall23");
        apply(mk(4'b0000, 32'hD331_D1D0, 0, FF, 1, 4'b0000, 0, 8'hD3, 3, 0, 1, 8'h5A), "stall24");
        apply(mk(4'b0000, 32'hD331_D1D0, 0, FF, 0, 4'b0000, 0, 8'hD3, 3, 0, 0, 8'h5A), "stall25");

        // Reset asserted while a stalled write is in flight.
        apply(mk(4'b0001, 32'hA5, 1, FF, 0, 4'b0001, 0, 8'hD3, 3, 0, 0, 8'h5A), "mid0");
        apply(mk(4'b1111, 32'hA5, 1, FF, 0, 4'b0000, 1, 8'hA5, 0, 0, 0, 8'h5A), "mid1");
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge hw_clk);
        tx_valid = 4'h0;
        resetn   = 1'b1;
`else
        // Echo: captured 0x41 is written before requester 1, with no tx_ready.
        apply(mk(4'b0000, 32'h6200, 0, 32'h41, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 8'h00), "echo0");
        apply(mk(4'b0010, 32'h6200, 1, FF,     1, 4'b0000, 0, 8'h00, 0, 1, 1, 8'h41), "echo1");
        apply(mk(4'b0010, 32'h6200, 1, 32'h42, 0, 4'b0000, 1, 8'h41, 0, 0, 0, 8'h41), "echo2");
        apply(mk(4'b0010, 32'h6200, 1, 32'h42, 0, 4'b0000, 1, 8'h41, 0, 0, 0, 8'h41), "echo3");
        apply(mk(4'b0010, 32'h6200, 0, 32'h42, 0, 4'b0000, 1, 8'h41, 0, 0, 0, 8'h41), "echo4");
        apply(mk(4'b0010, 32'h6200, 0, 32'h42, 0, 4'b0010, 0, 8'h41, 0, 0, 0, 8'h41), "echo5");
        apply(mk(4'b0000, 32'h6200, 0, FF,     0, 4'b0000, 1, 8'h62, 1, 1, 1, 8'h42), "echo6");
        apply(mk(4'b0000, 32'h6200, 0, FF,     0, 4'b0000, 0, 8'h62, 1, 0, 1, 8'h42), "echo7");
        apply(mk(4'b0011, 32'h6200, 0, FF,     0, 4'b0000, 1, 8'h42, 1, 0, 1, 8'h42), "echo8");
        apply(mk(4'b0011, 32'h6200, 0, FF,     0, 4'b0001, 0, 8'h42, 1, 0, 1, 8'h42), "echo9");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
